// File: rtl/jk_count_sequencer.sv
// Command sequencer that drives a bank of JK flip-flops: computes per-bit J/K
// from Q feedback to load, clear, or count the bank up/down by a programmed count.
module jk_count_sequencer #(
    parameter int WIDTH  = 4,
    parameter int STEP_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [WIDTH-1:0]  cmd_data,
    input  logic [STEP_W-1:0] cmd_steps,
    input  logic [WIDTH-1:0]  q_i,
    output logic [WIDTH-1:0]  j_o,
    output logic [WIDTH-1:0]  k_o,
    output logic              bank_rst,
    output logic              busy,
    output logic              done,
    output logic              tc
);

    localparam logic [1:0] OP_LOAD  = 2'b00;
    localparam logic [1:0] OP_UP    = 2'b01;
    localparam logic [1:0] OP_DOWN  = 2'b10;
    localparam logic [1:0] OP_CLEAR = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_COUNT = 3'd2,
        ST_CLEAR = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    state_t            state_r;
    state_t            state_nxt_s;
    logic [STEP_W-1:0] remaining_r;
    logic [STEP_W-1:0] remaining_nxt_s;
    logic [WIDTH-1:0]  data_r;
    logic              up_r;
    logic              ready_s;
    logic              accept_s;
    logic [WIDTH-1:0]  toggle_s;

    // Ready is forced low while reset is held even though the state already reads IDLE
    assign ready_s  = rst & (state_r == ST_IDLE);
    assign accept_s = cmd_valid & ready_s;

    // State and remaining-step register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r     <= ST_IDLE;
            remaining_r <= {STEP_W{1'b0}};
        end else begin
            state_r     <= state_nxt_s;
            remaining_r <= remaining_nxt_s;
        end
    end

    // Command operand capture at the handshake edge
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data_r <= {WIDTH{1'b0}};
            up_r   <= 1'b0;
        end else if (accept_s) begin
            data_r <= cmd_data;
            up_r   <= (cmd_op == OP_UP);
        end else begin
            data_r <= data_r;
            up_r   <= up_r;
        end
    end

    // Next-state and step-counter logic
    always_comb begin
        state_nxt_s     = state_r;
        remaining_nxt_s = remaining_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    case (cmd_op)
                        OP_LOAD:  state_nxt_s = ST_LOAD;
                        OP_CLEAR: state_nxt_s = ST_CLEAR;
                        OP_UP, OP_DOWN: begin
                            remaining_nxt_s = cmd_steps;
                            if (cmd_steps == {STEP_W{1'b0}}) begin
                                state_nxt_s = ST_DONE;
                            end else begin
                                state_nxt_s = ST_COUNT;
                            end
                        end
                        default:  state_nxt_s = ST_IDLE;
                    endcase
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_LOAD:  state_nxt_s = ST_DONE;
            ST_CLEAR: state_nxt_s = ST_DONE;
            ST_COUNT: begin
                remaining_nxt_s = remaining_r - STEP_W'(1);
                if (remaining_r == STEP_W'(1)) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_COUNT;
                end
            end
            ST_DONE:  state_nxt_s = ST_IDLE;
            default:  state_nxt_s = ST_IDLE;
        endcase
    end

    // Ripple toggle mask: a bit flips when every lower bit is at the wrap value
    always_comb begin
        logic ones_v;
        logic zeros_v;
        toggle_s = {WIDTH{1'b0}};
        ones_v   = 1'b1;
        zeros_v  = 1'b1;
        for (int i = 0; i < WIDTH; i++) begin
            if (up_r) begin
                toggle_s[i] = ones_v;
            end else begin
                toggle_s[i] = zeros_v;
            end
            ones_v  = ones_v & q_i[i];
            zeros_v = zeros_v & ~q_i[i];
        end
    end

    // J/K drive and terminal-count decode
    always_comb begin
        j_o = {WIDTH{1'b0}};
        k_o = {WIDTH{1'b0}};
        tc  = 1'b0;
        case (state_r)
            ST_LOAD: begin
                j_o = data_r;
                k_o = ~data_r;
            end
            ST_COUNT: begin
                j_o = toggle_s;
                k_o = toggle_s;
                if (up_r) begin
                    tc = &q_i;
                end else begin
                    tc = ~(|q_i);
                end
            end
            default: begin
                j_o = {WIDTH{1'b0}};
                k_o = {WIDTH{1'b0}};
                tc  = 1'b0;
            end
        endcase
    end

    assign cmd_ready = ready_s;
    assign busy      = ~ready_s;
    assign done      = rst & (state_r == ST_DONE);
    assign bank_rst  = ~rst | (state_r == ST_CLEAR);

endmodule

// File: tb/tb_jk_count_sequencer.sv
// Bench for jk_count_sequencer: a 4-bit JK bank closes the loop, and an
// arithmetic model of the bank value predicts q, tc, done and handshake timing.
module tb_jk_count_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [1:0] cmd_op = 2'b00;
    logic [3:0] cmd_data = 4'd0;
    logic [7:0] cmd_steps = 8'd0;
    logic [3:0] q_bank;
    logic [3:0] j_o;
    logic [3:0] k_o;
    logic       bank_rst;
    logic       busy;
    logic       done;
    logic       tc;

    int n_cmp = 0;
    int n_mis = 0;
    logic [3:0] q_exp;

    jk_count_sequencer #(.WIDTH(4), .STEP_W(8)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_data(cmd_data), .cmd_steps(cmd_steps),
        .q_i(q_bank), .j_o(j_o), .k_o(k_o),
        .bank_rst(bank_rst), .busy(busy), .done(done), .tc(tc)
    );

    always #5 clk = ~clk;

    // Four jkff instances with synchronous active-high reset
    always @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (bank_rst) q_bank[i] <= 1'b0;
            else begin
                case ({j_o[i], k_o[i]})
                    2'b01:   q_bank[i] <= 1'b0;
                    2'b10:   q_bank[i] <= 1'b1;
                    2'b11:   q_bank[i] <= ~q_bank[i];
                    default: q_bank[i] <= q_bank[i];
                endcase
            end
        end
    end

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // Full command transaction checked against the value model
    task automatic do_cmd(input logic [1:0] op, input logic [3:0] data, input logic [7:0] steps);
        int guard;
        logic up;
        logic [3:0] q_nxt;
        guard = 0;
        while (cmd_ready !== 1'b1 && guard < 20) begin
            step();
            guard++;
        end
        check_value("ready_wait", {31'd0, cmd_ready}, 32'd1);
        cmd_valid = 1'b1; cmd_op = op; cmd_data = data; cmd_steps = steps;
        step();
        cmd_valid = 1'b0; cmd_data = 4'($urandom); cmd_steps = 8'($urandom);
        check_value("busy_after_accept", {31'd0, busy}, 32'd1);
        if (op == 2'b00) begin
            check_value("load_j", {28'd0, j_o}, {28'd0, data});
            check_value("load_k", {28'd0, k_o}, {28'd0, ~data});
            check_value("load_done_early", {31'd0, done}, 32'd0);
            step();
            q_exp = data;
        end else if (op == 2'b11) begin
            check_value("clear_bank_rst", {31'd0, bank_rst}, 32'd1);
            check_value("clear_jk", {24'd0, j_o, k_o}, 32'd0);
            step();
            q_exp = 4'd0;
        end else begin
            up = (op == 2'b01);
            for (int s = 0; s < int'(steps); s++) begin
                q_nxt = up ? q_exp + 4'd1 : q_exp - 4'd1;
                check_value("count_q", {28'd0, q_bank}, {28'd0, q_exp});
                check_value("count_tc", {31'd0, tc}, {31'd0, up ? (q_exp == 4'd15) : (q_exp == 4'd0)});
                check_value("count_jk", {24'd0, j_o, k_o}, {24'd0, q_exp ^ q_nxt, q_exp ^ q_nxt});
                check_value("count_done_early", {31'd0, done}, 32'd0);
                step();
                q_exp = q_nxt;
            end
        end
        check_value("done_pulse", {31'd0, done}, 32'd1);
        check_value("done_q", {28'd0, q_bank}, {28'd0, q_exp});
        check_value("done_ready", {31'd0, cmd_ready}, 32'd0);
        check_value("done_jk", {24'd0, j_o, k_o}, 32'd0);
        step();
        check_value("post_done", {31'd0, done}, 32'd0);
        check_value("post_ready", {31'd0, cmd_ready}, 32'd1);
        check_value("post_q", {28'd0, q_bank}, {28'd0, q_exp});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset behaviour
        #1;
        check_value("rst_bank_rst", {31'd0, bank_rst}, 32'd1);
        check_value("rst_ready", {31'd0, cmd_ready}, 32'd0);
        check_value("rst_busy", {31'd0, busy}, 32'd1);
        repeat (3) step();
        rst = 1'b1;
        #1;
        q_exp = 4'd0;
        check_value("rel_q", {28'd0, q_bank}, 32'd0);
        check_value("rel_ready", {31'd0, cmd_ready}, 32'd1);
        check_value("rel_done", {31'd0, done}, 32'd0);
        check_value("rel_tc", {31'd0, tc}, 32'd0);

        // Directed sequences
        do_cmd(2'b00, 4'b1010, 8'd0);
        do_cmd(2'b00, 4'b1110, 8'd0);
        do_cmd(2'b01, 4'b0000, 8'd3);
        do_cmd(2'b00, 4'b0001, 8'd0);
        do_cmd(2'b10, 4'b0000, 8'd2);
        do_cmd(2'b01, 4'b0000, 8'd0);
        check_value("zero_step_q", {28'd0, q_bank}, 32'd15);

        // Reset in the middle of a long count
        do_cmd(2'b11, 4'b0000, 8'd0);
        cmd_valid = 1'b1; cmd_op = 2'b01; cmd_steps = 8'd200;
        step();
        cmd_valid = 1'b0;
        for (int s = 0; s < 50; s++) begin
            check_value("long_done", {31'd0, done}, 32'd0);
            step();
            q_exp = q_exp + 4'd1;
        end
        check_value("long_q", {28'd0, q_bank}, {28'd0, q_exp});
        rst = 1'b0;
        #1;
        check_value("mid_rst_bank_rst", {31'd0, bank_rst}, 32'd1);
        check_value("mid_rst_ready", {31'd0, cmd_ready}, 32'd0);
        check_value("mid_rst_busy", {31'd0, busy}, 32'd1);
        check_value("mid_rst_tc", {31'd0, tc}, 32'd0);
        check_value("mid_rst_jk", {24'd0, j_o, k_o}, 32'd0);
        step();
        check_value("mid_rst_q", {28'd0, q_bank}, 32'd0);
        check_value("mid_rst_done", {31'd0, done}, 32'd0);
        step();
        rst = 1'b1;
        q_exp = 4'd0;
        step();
        check_value("rerel_ready", {31'd0, cmd_ready}, 32'd1);
        check_value("rerel_done", {31'd0, done}, 32'd0);
        check_value("rerel_q", {28'd0, q_bank}, 32'd0);

        // CLEAR with cmd_valid held: next command waits for the cycle after DONE
        do_cmd(2'b00, 4'b0110, 8'd0);
        cmd_valid = 1'b1; cmd_op = 2'b11;
        step();
        cmd_op = 2'b00; cmd_data = 4'b0101;
        check_value("hold_bank_rst", {31'd0, bank_rst}, 32'd1);
        check_value("hold_ready_clr", {31'd0, cmd_ready}, 32'd0);
        step();
        check_value("hold_q_clr", {28'd0, q_bank}, 32'd0);
        check_value("hold_done", {31'd0, done}, 32'd1);
        check_value("hold_ready_done", {31'd0, cmd_ready}, 32'd0);
        check_value("hold_bank_rst_done", {31'd0, bank_rst}, 32'd0);
        step();
        check_value("hold_done_gone", {31'd0, done}, 32'd0);
        check_value("hold_ready_idle", {31'd0, cmd_ready}, 32'd1);
        step();
        cmd_valid = 1'b0;
        check_value("hold_q_not_early", {28'd0, q_bank}, 32'd0);
        check_value("hold_busy_load", {31'd0, busy}, 32'd1);
        step();
        check_value("hold_q_loaded", {28'd0, q_bank}, 32'd5);
        check_value("hold_done2", {31'd0, done}, 32'd1);
        step();
        q_exp = 4'b0101;

        // Randomized command stream
        for (int t = 0; t < 30; t++) begin
            do_cmd(2'($urandom_range(0, 3)), 4'($urandom), 8'($urandom_range(0, 20)));
            repeat ($urandom_range(0, 2)) begin
                check_value("idle_jk", {24'd0, j_o, k_o}, 32'd0);
                check_value("idle_done", {31'd0, done}, 32'd0);
                step();
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
